// File: rtl/scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : scan_decoder
// Brief    : Registered N-to-2^N decoder with one-hot, thermometer,
//            active-low and auto-scan walking-one modes.
// Revision : 1.0
// ============================================================================
module scan_decoder #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      din,
    input  logic                  load,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [2**SEL_W-1:0]   dout,
    output logic                  valid,
    output logic [SEL_W-1:0]      scan_idx,
    output logic                  wrap
);

    localparam int OUT_W = 2**SEL_W;

    localparam logic [1:0] C_MODE_ONEHOT = 2'b00;
    localparam logic [1:0] C_MODE_THERM  = 2'b01;
    localparam logic [1:0] C_MODE_SCAN   = 2'b10;
    localparam logic [1:0] C_MODE_ACTLOW = 2'b11;

    typedef enum logic [0:0] {
        ST_DECODE = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [OUT_W-1:0]     r_dout, w_dout_nxt;
    logic                 r_valid, w_valid_nxt;
    logic [SEL_W-1:0]     r_scan_idx, w_idx_nxt;
    logic                 r_wrap, w_wrap_nxt;
    logic [DWELL_W-1:0]   r_cnt, w_cnt_nxt;
    logic [DWELL_W-1:0]   r_cap, w_cap_nxt;
    logic [OUT_W-1:0]     w_therm;

    always_comb begin
        w_therm = '0;
        for (int i = 0; i < OUT_W; i++) begin
            w_therm[i] = (SEL_W'(i) <= din);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_DECODE;
            r_dout     <= '0;
            r_valid    <= 1'b0;
            r_scan_idx <= '0;
            r_wrap     <= 1'b0;
            r_cnt      <= '0;
            r_cap      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_dout     <= w_dout_nxt;
            r_valid    <= w_valid_nxt;
            r_scan_idx <= w_idx_nxt;
            r_wrap     <= w_wrap_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cap      <= w_cap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = (mode == C_MODE_SCAN) ? ST_SCAN : ST_DECODE;
        w_dout_nxt  = '0;
        w_valid_nxt = enable;
        w_idx_nxt   = r_scan_idx;
        w_wrap_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_cap_nxt   = r_cap;

        if (mode == C_MODE_SCAN) begin
            // Entry and load both restart the walk; load wins over advance.
            if (r_state == ST_DECODE || load) begin
                w_idx_nxt = din;
                w_cap_nxt = dwell;
                w_cnt_nxt = '0;
            end else if (enable) begin
                if (r_cnt == r_cap) begin
                    w_cnt_nxt  = '0;
                    w_idx_nxt  = r_scan_idx + SEL_W'(1);
                    w_wrap_nxt = (r_scan_idx == {SEL_W{1'b1}});
                end else begin
                    w_cnt_nxt = r_cnt + DWELL_W'(1);
                end
            end
            if (enable) begin
                w_dout_nxt = OUT_W'(1) << w_idx_nxt;
            end
        end else if (enable) begin
            case (mode)
                C_MODE_ONEHOT: w_dout_nxt = OUT_W'(1) << din;
                C_MODE_THERM:  w_dout_nxt = w_therm;
                C_MODE_ACTLOW: w_dout_nxt = ~(OUT_W'(1) << din);
                default:       w_dout_nxt = '0;
            endcase
        end else if (mode == C_MODE_ACTLOW) begin
            // Blanked active-low lines idle high.
            w_dout_nxt = '1;
        end
    end

    assign dout     = r_dout;
    assign valid    = r_valid;
    assign scan_idx = r_scan_idx;
    assign wrap     = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_decoder
// Brief    : Directed plus randomized check of scan_decoder against a
//            behavioural reference model.
// Revision : 1.0
// ============================================================================
module tb_scan_decoder;

    localparam int SEL_W   = 3;
    localparam int DWELL_W = 8;
    localparam int OUT_W   = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic [1:0]         mode;
    logic [SEL_W-1:0]   din;
    logic               load;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   dout;
    logic               valid;
    logic [SEL_W-1:0]   scan_idx;
    logic               wrap;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit m_scan;
    int m_idx, m_cnt, m_cap;
    int e_dout;
    bit e_valid, e_wrap;

    scan_decoder #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .mode     (mode),
        .din      (din),
        .load     (load),
        .dwell    (dwell),
        .dout     (dout),
        .valid    (valid),
        .scan_idx (scan_idx),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_scan = 0; m_idx = 0; m_cnt = 0; m_cap = 0;
        e_dout = 0; e_valid = 0; e_wrap = 0;
    endtask

    task automatic model_tick();
        if (mode == 2'b10) begin
            e_wrap = 0;
            if (!m_scan || load) begin
                m_idx = int'(din); m_cap = int'(dwell); m_cnt = 0;
            end else if (enable) begin
                if (m_cnt == m_cap) begin
                    m_cnt  = 0;
                    e_wrap = (m_idx == OUT_W - 1);
                    m_idx  = (m_idx + 1) % OUT_W;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            e_dout  = enable ? (1 << m_idx) : 0;
            e_valid = enable;
            m_scan  = 1;
        end else begin
            m_scan  = 0;
            e_wrap  = 0;
            e_valid = enable;
            if (!enable)
                e_dout = (mode == 2'b11) ? (1 << OUT_W) - 1 : 0;
            else if (mode == 2'b00)
                e_dout = 1 << din;
            else if (mode == 2'b01)
                e_dout = (2 << din) - 1;
            else
                e_dout = ((1 << OUT_W) - 1) - (1 << din);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_tick();
        #1;
        check({tag, ".dout"},  32'(dout),     32'(e_dout));
        check({tag, ".valid"}, 32'(valid),    32'(e_valid));
        check({tag, ".idx"},   32'(scan_idx), 32'(m_idx));
        check({tag, ".wrap"},  32'(wrap),     32'(e_wrap));
    endtask

    task automatic drive(input logic en, input logic [1:0] md, input int d,
                         input logic ld, input int dw);
        enable = en; mode = md; din = SEL_W'(d); load = ld; dwell = DWELL_W'(dw);
    endtask

    logic [7:0] scan_seq [7] = '{8'h40, 8'h40, 8'h40, 8'h80, 8'h80, 8'h80, 8'h01};

    initial begin
        rst = 1'b1;
        drive(0, 2'b00, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst.dout", 32'(dout), 32'h0);
        check("rst.valid", 32'(valid), 32'h0);
        check("rst.idx", 32'(scan_idx), 32'h0);
        check("rst.wrap", 32'(wrap), 32'h0);
        rst = 1'b0;

        drive(1, 2'b00, 5, 0, 0);
        step("onehot5");
        check("onehot5.const", 32'(dout), 32'h20);

        // Asynchronous reset between edges
        #3 rst = 1'b1;
        #1;
        check("arst.dout", 32'(dout), 32'h0);
        check("arst.valid", 32'(valid), 32'h0);
        model_reset();
        #2 rst = 1'b0;

        for (int d = 0; d < OUT_W; d++) begin
            drive(1, 2'b01, d, 0, 0);
            step("therm");
            check("therm.const", 32'(dout), 32'((2 << d) - 1));
        end

        drive(1, 2'b11, 2, 0, 0);
        step("actlow2");
        check("actlow2.const", 32'(dout), 32'hFB);

        drive(1, 2'b10, 6, 0, 2);
        for (int k = 0; k < 7; k++) begin
            step("scan_d2");
            check("scan_d2.seq", 32'(dout), 32'(scan_seq[k]));
        end
        check("scan_d2.wrap", 32'(wrap), 32'h1);
        check("scan_d2.idx0", 32'(scan_idx), 32'h0);

        drive(1, 2'b00, 0, 0, 0);
        step("leave");
        drive(1, 2'b10, 0, 0, 0);
        for (int k = 0; k < 17; k++) step("scan_d0");

        drive(1, 2'b10, 3, 1, 1);
        step("load");
        check("load.const", 32'(dout), 32'h08);
        load = 1'b0;
        step("load_hold");
        check("load_hold.const", 32'(dout), 32'h08);
        step("load_next");
        check("load_next.const", 32'(dout), 32'h10);

        drive(1, 2'b10, 4, 1, 2);
        step("pause_load");
        load = 1'b0;
        step("pause_cnt1");
        enable = 1'b0;
        for (int k = 0; k < 5; k++) step("paused");
        check("paused.idx", 32'(scan_idx), 32'h4);
        check("paused.dout", 32'(dout), 32'h0);
        enable = 1'b1;
        step("resume");
        check("resume.const", 32'(dout), 32'h10);
        step("resume_adv");
        check("resume_adv.const", 32'(dout), 32'h20);

        drive(0, 2'b11, 0, 0, 0);
        step("actlow_off");
        check("actlow_off.const", 32'(dout), 32'hFF);
        drive(1, 2'b10, 7, 0, 0);
        step("to_scan");
        drive(1, 2'b00, 1, 0, 0);
        step("scan_exit");
        check("scan_exit.const", 32'(dout), 32'h02);
        check("scan_exit.wrap", 32'(wrap), 32'h0);

        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            enable = ($urandom_range(0, 9) != 0);
            din    = SEL_W'($urandom);
            load   = ($urandom_range(0, 19) == 0);
            dwell  = DWELL_W'($urandom_range(0, 3));
            if (mode == 2'b10 && !m_scan) enable = 1'b1;
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
